// File: rtl/scan_scheduler_pkg.sv
// Shared constants for the scan scheduler: FSM state encoding and default sizes.
package scan_scheduler_pkg;

  localparam int CH_NUM_DEF    = 16;
  localparam int WORD_BITS_DEF = 12;
  localparam int PERIOD_W_DEF  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

endpackage

// File: rtl/scan_scheduler_next_ch.sv
// Combinational finder: lowest enabled channel above (or at, when inclusive) a start index.
module scan_next_ch
  import scan_scheduler_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int CH_W   = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] mask,
  input  logic [CH_W-1:0]   from_ch,
  input  logic              inclusive,
  output logic [CH_W-1:0]   nxt_ch,
  output logic              none
);

  // Scanning downward so the last hit written is the lowest qualifying channel.
  always_comb begin
    nxt_ch = '0;
    none   = 1'b1;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from_ch)) || (inclusive && (i == int'(from_ch))))) begin
        nxt_ch = CH_W'(i);
        none   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_scheduler.sv
// Frame scheduler: divides the tick timebase into frame requests and walks the enabled channels.
module scan_scheduler
  import scan_scheduler_pkg::*;
#(
  parameter int CH_NUM    = CH_NUM_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int PERIOD_W  = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CH_NUM-1:0]   ch_mask,
  input  logic                host_ready,
  output logic [3:0]          sel,
  output logic                sl,
  output logic                shift_en,
  output logic                frame_active,
  output logic                clr,
  output logic                frame_done,
  output logic [7:0]          drop_cnt
);

  localparam int CH_W = $clog2(CH_NUM);
  localparam int BC_W = $clog2(WORD_BITS + 1);

  logic [1:0]          state;
  logic [CH_W-1:0]     cur_ch;
  logic [BC_W-1:0]     bit_cnt;
  logic [CH_NUM-1:0]   mask_q;
  logic [PERIOD_W-1:0] tcnt;
  logic                pending;

  logic                req;
  logic                consume;
  logic                drop;
  logic                last_shift;
  logic                idle;
  logic [CH_NUM-1:0]   find_mask;
  logic [CH_W-1:0]     find_from;
  logic [CH_W-1:0]     nxt_ch;
  logic                none_left;

  // In IDLE the finder looks at the live mask from channel 0; mid-frame it walks the latched copy.
  always_comb begin
    idle       = (state == ST_IDLE);
    req        = tick && (period != '0) && (tcnt >= (period - PERIOD_W'(1)));
    consume    = idle && pending && host_ready;
    drop       = req && pending && !consume;
    last_shift = (state == ST_SHIFT) && (bit_cnt == BC_W'(WORD_BITS - 1));
    find_mask  = idle ? ch_mask : mask_q;
    find_from  = idle ? '0 : cur_ch;
  end

  scan_next_ch #(
    .CH_NUM (CH_NUM),
    .CH_W   (CH_W)
  ) u_next_ch (
    .mask      (find_mask),
    .from_ch   (find_from),
    .inclusive (idle),
    .nxt_ch    (nxt_ch),
    .none      (none_left)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (period == '0) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= req ? '0 : tcnt + PERIOD_W'(1);
    end
  end

  // A request coinciding with consumption re-arms the flag instead of counting as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (req) begin
        pending <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cur_ch  <= '0;
      bit_cnt <= '0;
      mask_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (consume) begin
            mask_q <= ch_mask;
            if (none_left) begin
              state <= ST_CLEAR;
            end else begin
              state  <= ST_LOAD;
              cur_ch <= nxt_ch;
            end
          end
        end
        ST_LOAD: begin
          state   <= ST_SHIFT;
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          if (last_shift) begin
            if (none_left) begin
              state <= ST_CLEAR;
            end else begin
              state  <= ST_LOAD;
              cur_ch <= nxt_ch;
            end
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sl           = (state == ST_LOAD);
    shift_en     = (state == ST_SHIFT);
    frame_active = (state != ST_IDLE);
    clr          = (state == ST_CLEAR);
    frame_done   = (state == ST_CLEAR);
    sel          = (sl || shift_en) ? 4'(cur_ch) : 4'd0;
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// Bench for scan_scheduler: frame-level reference model plus directed timing checks.
module tb_scan_scheduler;

  localparam int WB = 12;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [15:0] period;
  logic [15:0] ch_mask;
  logic        host_ready;
  logic [3:0]  sel;
  logic        sl;
  logic        shift_en;
  logic        frame_active;
  logic        clr;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  typedef struct packed {
    logic [3:0] sel;
    logic       sl;
    logic       sh;
    logic       clr;
  } slot_t;

  slot_t fq[$];
  int    m_tcnt;
  bit    m_pend;
  int    m_drops;

  int n_cmp;
  int n_bad;
  int cyc;
  int sl_cyc[$];
  int sl_sel[$];
  int clr_cyc[$];
  int sh_count;

  scan_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .period       (period),
    .ch_mask      (ch_mask),
    .host_ready   (host_ready),
    .sel          (sel),
    .sl           (sl),
    .shift_en     (shift_en),
    .frame_active (frame_active),
    .clr          (clr),
    .frame_done   (frame_done),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [8:0] modelOuts();
    if (fq.size() == 0) return 9'd0;
    return {fq[0].sel, fq[0].sl, fq[0].sh, 1'b1, fq[0].clr, fq[0].clr};
  endfunction

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1000;
  endfunction

  // A frame is expanded into its full per-cycle output list the moment it is granted.
  task automatic modelAdvance(input logic t, input logic [15:0] p, input logic [15:0] m, input logic hr);
    bit    consume;
    bit    req;
    slot_t s;
    consume = (fq.size() == 0) && m_pend && hr;
    req = 0;
    if (p == 0) m_tcnt = 0;
    else if (t) begin
      if (m_tcnt >= int'(p) - 1) begin
        req = 1;
        m_tcnt = 0;
      end else m_tcnt++;
    end
    if (fq.size() > 0) void'(fq.pop_front());
    else if (consume) begin
      for (int ch = 0; ch < 16; ch++) begin
        if (m[ch]) begin
          s.sel = 4'(ch); s.sl = 1'b1; s.sh = 1'b0; s.clr = 1'b0;
          fq.push_back(s);
          s.sl = 1'b0; s.sh = 1'b1;
          repeat (WB) fq.push_back(s);
        end
      end
      s.sel = 4'd0; s.sl = 1'b0; s.sh = 1'b0; s.clr = 1'b1;
      fq.push_back(s);
    end
    if (req) begin
      if (m_pend && !consume) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      m_pend = 1;
    end else if (consume) m_pend = 0;
  endtask

  task automatic applyStimulus(input logic t, input logic [15:0] p, input logic [15:0] m, input logic hr);
    @(negedge clk);
    checkOutput("outs", {sel, sl, shift_en, frame_active, clr, frame_done}, modelOuts());
    checkOutput("drop", drop_cnt, 16'(m_drops));
    if (sl === 1'b1) begin
      sl_cyc.push_back(cyc);
      sl_sel.push_back(int'(sel));
    end
    if (clr === 1'b1) clr_cyc.push_back(cyc);
    if (shift_en === 1'b1) sh_count++;
    tick = t;
    period = p;
    ch_mask = m;
    host_ready = hr;
    modelAdvance(t, p, m, hr);
    cyc++;
  endtask

  task automatic doReset();
    tick = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_outs", {sel, sl, shift_en, frame_active, clr, frame_done}, 16'd0);
    checkOutput("rst_async_drop", drop_cnt, 16'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_hold_outs", {sel, sl, shift_en, frame_active, clr, frame_done}, 16'd0);
    fq.delete();
    m_tcnt = 0;
    m_pend = 0;
    m_drops = 0;
    sl_cyc.delete();
    sl_sel.delete();
    clr_cyc.delete();
    sh_count = 0;
    reset = 1'b0;
  endtask

  initial begin
    int   n;
    bit   found;
    logic [15:0] rp;
    logic [15:0] rm;
    n_cmp = 0; n_bad = 0; cyc = 0; n = 0;
    tick = 0; period = 0; ch_mask = 0; host_ready = 0; reset = 0;
    doReset();

    // Two-channel frame, request on every second tick.
    for (int i = 0; i < 1000; i++) begin
      if (i == 10) n = cyc;
      applyStimulus(i % 10 == 0, 16'd2, 16'h0005, 1'b1);
    end
    checkOutput("sl0_time", 16'(qget(sl_cyc, 0) - n), 16'd2);
    checkOutput("sl0_sel", 16'(qget(sl_sel, 0)), 16'd0);
    checkOutput("sl1_time", 16'(qget(sl_cyc, 1) - n), 16'd15);
    checkOutput("sl1_sel", 16'(qget(sl_sel, 1)), 16'd2);
    checkOutput("clr_time", 16'(qget(clr_cyc, 0) - n), 16'd28);
    doReset();

    // All channels, tick every cycle: long frames and saturating drops.
    for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 16'd1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 16; i++) checkOutput("full_sel", 16'(qget(sl_sel, i)), 16'(i));
    checkOutput("full_len", 16'(qget(clr_cyc, 0) - qget(sl_cyc, 0)), 16'd208);
    checkOutput("drop_sat", drop_cnt, 16'd255);
    doReset();

    // Empty mask: frame collapses to a single CLEAR.
    n = cyc;
    applyStimulus(1'b1, 16'd1, 16'h0000, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 16'd1, 16'h0000, 1'b1);
    checkOutput("empty_clr", 16'(qget(clr_cyc, 0) - n), 16'd2);
    checkOutput("empty_sl", 16'(sl_cyc.size()), 16'd0);
    checkOutput("empty_sh", 16'(sh_count), 16'd0);
    doReset();

    // Host not ready: second request dropped, then exactly one frame.
    applyStimulus(1'b1, 16'd1, 16'h0003, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'd1, 16'h0003, 1'b0);
    applyStimulus(1'b1, 16'd1, 16'h0003, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'd1, 16'h0003, 1'b0);
    checkOutput("hold_drop", drop_cnt, 16'd1);
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 16'd1, 16'h0003, 1'b1);
    checkOutput("hold_frames", 16'(clr_cyc.size()), 16'd1);
    checkOutput("hold_loads", 16'(sl_cyc.size()), 16'd2);
    doReset();

    // Reset in the middle of channel 3's shift phase.
    found = 0;
    applyStimulus(1'b1, 16'd1, 16'h000F, 1'b1);
    for (int i = 0; i < 300 && !found; i++) begin
      applyStimulus(1'b0, 16'd1, 16'h000F, 1'b1);
      if (fq.size() > 0 && fq[0].sh && fq[0].sel == 4'd3) found = 1;
    end
    repeat (3) applyStimulus(1'b0, 16'd1, 16'h000F, 1'b1);
    checkOutput("wait_ch3", 16'(found), 16'd1);
    #2;
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'd1, 16'h000F, 1'b1);
    checkOutput("post_rst_idle", 16'(clr_cyc.size()), 16'd0);
    applyStimulus(1'b1, 16'd1, 16'h000F, 1'b1);
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 16'd1, 16'h000F, 1'b1);
    checkOutput("post_rst_frame", 16'(clr_cyc.size()), 16'd1);
    doReset();

    // Period zero disables requests entirely.
    for (int i = 0; i < 300; i++) applyStimulus(1'($urandom_range(0, 1)), 16'd0, 16'($urandom), 1'b1);
    checkOutput("p0_frames", 16'(clr_cyc.size()), 16'd0);
    checkOutput("p0_drop", drop_cnt, 16'd0);
    doReset();

    // Random traffic with mid-frame mask and period changes.
    rp = 16'd1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) rp = 16'($urandom_range(0, 4));
      rm = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus($urandom_range(0, 2) == 0, rp, rm, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_scheduler.md
SCAN_SCHEDULER -- requirements
Module: scan_scheduler

Interface
REQ-001 Parameter CH_NUM, default 16: number of filter channels scanned per frame; channel index 0 is the RTC word.
REQ-002 Parameter WORD_BITS, default 12: bits shifted out per channel slot.
REQ-003 Parameter PERIOD_W, default 16: width of the frame-period register.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick  in  1  one-cycle timebase overflow pulse.
REQ-007 period  in  PERIOD_W  ticks between frame requests; 0 disables frame requests.
REQ-008 ch_mask  in  CH_NUM  channel enable mask, bit i enables channel i.
REQ-009 host_ready  in  1  downstream serializer ready to accept a frame.
REQ-010 sel  out  4  channel select for the readout mux.
REQ-011 sl  out  1  shift/load pulse on the first cycle of each channel slot.
REQ-012 shift_en  out  1  high on each shift cycle of a slot.
REQ-013 frame_active  out  1  high from the first LOAD to CLEAR inclusive.
REQ-014 clr  out  1  one-cycle accumulator clear at the end of each frame.
REQ-015 frame_done  out  1  one-cycle pulse, coincident with clr.
REQ-016 drop_cnt  out  8  saturating count of dropped frame requests.

Function
REQ-017 Tick counter tcnt: on tick, if tcnt >= period-1, raise frame request and set tcnt to 0; otherwise increment tcnt; when period==0, hold tcnt at 0 and raise no requests.
REQ-018 A frame request sets the single-entry pending flag; pending becomes visible the cycle after the tick.
REQ-019 A request arriving while pending is set (and not being consumed in that cycle) is dropped; drop_cnt increments and saturates at 255.
REQ-020 A request in the same cycle as pending is consumed re-arms pending and is not dropped.
REQ-021 A request during frame_active sets pending if it is clear, otherwise it is dropped.
REQ-022 FSM states are IDLE, LOAD, SHIFT and CLEAR.
REQ-023 IDLE: when pending && host_ready, clear pending, latch ch_mask into mask_q, and go to LOAD at the lowest enabled channel; if ch_mask==0, go directly to CLEAR.
REQ-024 LOAD lasts 1 cycle with sl=1, shift_en=0 and sel=current channel, then goes to SHIFT.
REQ-025 SHIFT lasts exactly WORD_BITS cycles with shift_en=1, sl=0 and sel held.
REQ-026 After the last shift cycle, go to LOAD at the next higher enabled channel in mask_q, or to CLEAR if none remains.
REQ-027 CLEAR lasts 1 cycle with clr=1, frame_done=1 and sel=0, then goes to IDLE.
REQ-028 Frame length for k enabled channels is k*(WORD_BITS+1)+1 cycles.
REQ-029 ch_mask changes mid-frame are ignored; period changes take effect at the next tick.
REQ-030 host_ready is sampled only in IDLE; deasserting it mid-frame does not stall the frame.
REQ-031 In IDLE, sel=0 and sl, shift_en, clr, frame_done and frame_active are all 0.

Reset
REQ-032 Reset asserted at any time, including mid-frame, forces state=IDLE, tcnt=0, pending=0, mask_q=0, drop_cnt=0, sel=0 and all 1-bit outputs to 0, without waiting for a clock edge.
REQ-033 After reset deassertion, the first tick counts as tick 1 of period.

Structure
REQ-034 A shared package holds the FSM state encoding and the CH_NUM/WORD_BITS defaults.
REQ-035 One sub-module, scan_next_ch, is instantiated: a combinational finder returning the next enabled channel index above a given index, plus a none-left flag.
REQ-036 The FSM, tick counter, pending flag and drop counter live in scan_scheduler.

Verification
REQ-037 Cycle numbering: the cycle with tick high is cycle N; each scenario runs 1000 cycles with no X on any output.
REQ-038 period=2, ch_mask=16'h0005, host_ready=1, ticks every 10 cycles -> after 2nd tick (cycle N): sl at N+2 with sel=0; sl at N+15 with sel=2; clr/frame_done at N+28; frame_active high N+2..N+28.
REQ-039 period=1, ch_mask=16'hFFFF, tick every cycle -> frame of 16*13+1=209 cycles with sel stepping 0..15; drop_cnt saturates at 255.
REQ-040 ch_mask=0, period=1, single tick -> clr/frame_done at N+2; no sl, no shift_en.
REQ-041 host_ready=0 while request pending, then a 2nd request -> drop_cnt=1; host_ready=1 -> exactly one frame starts.
REQ-042 Reset asserted during SHIFT of channel 3 -> all outputs 0 immediately; pending=0; the next frame starts only after new ticks.
REQ-043 period=0 with ticks applied -> no frames started and drop_cnt remains 0.
